// File: rtl/hdlc_rx_pkg.sv
// Shared constants and state-index helpers for the HDLC receive deframer.
// Holds the default run length and word width, the bit positions of each
// one-hot state, and the state-count function used to size the state vector.
package hdlc_rx_pkg;

  localparam int unsigned RUN_LEN_DEF = 5;
  localparam int unsigned DATA_W_DEF  = 8;

  // Bit position of count state Ck (k consecutive 1s seen).
  function automatic int unsigned c_idx(input int unsigned k);
    return k;
  endfunction

  function automatic int unsigned err_idx(input int unsigned run_len);
    return run_len + 2;
  endfunction

  function automatic int unsigned disc_idx(input int unsigned run_len);
    return run_len + 3;
  endfunction

  function automatic int unsigned flag_idx(input int unsigned run_len);
    return run_len + 4;
  endfunction

  // Number of one-hot states for a given run length.
  function automatic int unsigned NS(input int unsigned run_len);
    return run_len + 5;
  endfunction

endpackage

// File: rtl/hdlc_run_fsm.sv
// One-hot run-length tracker for the HDLC receive deframer.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   in_valid, in    - qualified line bit
//   state           - registered one-hot state (C0..C(RUN_LEN+1), ERR, DISC, FLAG)
//   disc_entry_c    - accepted bit moves into DISC (combinational)
//   flag_entry_c    - accepted bit moves into FLAG (combinational)
//   err_entry_c     - accepted bit moves into ERR from outside ERR (combinational)
module hdlc_run_fsm
  import hdlc_rx_pkg::*;
#(
  parameter int unsigned  RUN_LEN = RUN_LEN_DEF,
  localparam int unsigned NSTATE  = hdlc_rx_pkg::NS(RUN_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in,
  output logic [NSTATE-1:0] state,
  output logic              disc_entry_c,
  output logic              flag_entry_c,
  output logic              err_entry_c
);

  localparam int unsigned C_0    = c_idx(0);
  localparam int unsigned C_1    = c_idx(1);
  localparam int unsigned C_2    = c_idx(2);
  localparam int unsigned C_RUN  = c_idx(RUN_LEN);
  localparam int unsigned C_TOP  = c_idx(RUN_LEN + 1);
  localparam int unsigned ERR_I  = err_idx(RUN_LEN);
  localparam int unsigned DISC_I = disc_idx(RUN_LEN);
  localparam int unsigned FLAG_I = flag_idx(RUN_LEN);

  logic [NSTATE-1:0] state_nxt;
  logic              c0_pred;

  // State register; frozen while in_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NSTATE'(1);
    end else if (in_valid) begin
      state <= state_nxt;
    end
  end

  // Per-bit next state: OR of predecessor bits gated by the line bit, so a
  // corrupted vector propagates bitwise instead of being decoded as a whole.
  always_comb begin
    state_nxt = '0;
    c0_pred   = (|state[C_RUN-1:C_0]) | state[ERR_I] | state[DISC_I] | state[FLAG_I];

    state_nxt[C_0]         = ~in & c0_pred;
    state_nxt[C_1]         = in & (state[C_0] | state[DISC_I] | state[FLAG_I]);
    state_nxt[C_TOP:C_2]   = {RUN_LEN{in}} & state[C_RUN:C_1];
    state_nxt[ERR_I]       = in & (state[C_TOP] | state[ERR_I]);
    state_nxt[DISC_I]      = ~in & state[C_RUN];
    state_nxt[FLAG_I]      = ~in & state[C_TOP];
  end

  assign disc_entry_c = in_valid & state_nxt[DISC_I];
  assign flag_entry_c = in_valid & state_nxt[FLAG_I];
  // Staying in ERR is not a new abort.
  assign err_entry_c  = in_valid & state_nxt[ERR_I] & ~state[ERR_I];

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: removes stuffed zeros, detects flags and aborts,
// and assembles the unstuffed payload into LSB-first words.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   in_valid, in  - qualified line bit from the sampler
//   state         - registered one-hot run-length state (debug)
//   flag          - pulse: flag recognised
//   discard       - pulse: stuffed zero removed
//   abort         - pulse: entry to ERR (7+ ones with defaults)
//   frame_active  - level: inside a frame (set by flag, cleared by abort)
//   data          - last completed word, held between words
//   data_valid    - pulse: data updated with a new word
//   frame_err     - pulse with flag when the closed frame was misaligned
module hdlc_rx_deframer
  import hdlc_rx_pkg::*;
#(
  parameter int unsigned  RUN_LEN = RUN_LEN_DEF,
  parameter int unsigned  DATA_W  = DATA_W_DEF,
  localparam int unsigned NS      = hdlc_rx_pkg::NS(RUN_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in,
  output logic [NS-1:0]     state,
  output logic              flag,
  output logic              discard,
  output logic              abort,
  output logic              frame_active,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err
);

  localparam int unsigned CNT_W   = $clog2(DATA_W);
  // Leading flag bits (0 then RUN_LEN+1 ones) are shifted in as data before
  // the flag is seen, so an aligned frame ends with exactly this residue.
  localparam int unsigned RESIDUE = RUN_LEN + 2;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic              disc_entry_c;
  logic              flag_entry_c;
  logic              err_entry_c;
  logic              data_bit_c;

  hdlc_run_fsm #(
    .RUN_LEN (RUN_LEN)
  ) u_run_fsm (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in           (in),
    .state        (state),
    .disc_entry_c (disc_entry_c),
    .flag_entry_c (flag_entry_c),
    .err_entry_c  (err_entry_c)
  );

  assign data_bit_c = in_valid & frame_active & ~(disc_entry_c | flag_entry_c | err_entry_c);
  // Shift in from the MSB so the first bit ends up in bit 0.
  assign shreg_nxt  = {in, shreg[DATA_W-1:1]};

  // Word assembler, frame tracking and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      shreg        <= '0;
      frame_active <= 1'b0;
      data         <= '0;
      flag         <= 1'b0;
      discard      <= 1'b0;
      abort        <= 1'b0;
      data_valid   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      flag       <= 1'b0;
      discard    <= 1'b0;
      abort      <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (flag_entry_c) begin
        flag         <= 1'b1;
        frame_err    <= frame_active && (cnt != CNT_W'(RESIDUE));
        cnt          <= '0;
        shreg        <= '0;
        frame_active <= 1'b1;
      end else if (err_entry_c) begin
        abort        <= 1'b1;
        frame_active <= 1'b0;
        cnt          <= '0;
      end else if (disc_entry_c) begin
        discard <= 1'b1;
      end else if (data_bit_c) begin
        shreg <= shreg_nxt;
        if (cnt == CNT_W'(DATA_W - 1)) begin
          data       <= shreg_nxt;
          data_valid <= 1'b1;
          cnt        <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Randomised self-checking bench for hdlc_rx_deframer: a run-length model
// predicts every output each cycle for a default instance and a RUN_LEN=3,
// DATA_W=6 instance, plus literal checks for the directed scenarios.
module tb_hdlc_rx_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       va, ia, vb, ib;

  logic [9:0] state_a;
  logic       flag_a, disc_a, abort_a, fa_a, dv_a, ferr_a;
  logic [7:0] data_a;

  logic [7:0] state_b;
  logic       flag_b, disc_b, abort_b, fa_b, dv_b, ferr_b;
  logic [5:0] data_b;

  hdlc_rx_deframer u_dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .in(ia), .state(state_a),
    .flag(flag_a), .discard(disc_a), .abort(abort_a), .frame_active(fa_a),
    .data(data_a), .data_valid(dv_a), .frame_err(ferr_a)
  );

  hdlc_rx_deframer #(.RUN_LEN(3), .DATA_W(6)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in(ib), .state(state_b),
    .flag(flag_b), .discard(disc_b), .abort(abort_b), .frame_active(fa_b),
    .data(data_b), .data_valid(dv_b), .frame_err(ferr_b)
  );

  // Behavioural model: tracks the length of the current run of 1s and the
  // unstuffed bits collected since the last word/flag.
  typedef struct {
    int ones;
    bit active;
    int cnt;
    int word;
    int sidx;
    bit flag, disc, abrt, dv, ferr;
    int data;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input bit rst, input bit v, input bit b,
                                input int r, input int w);
    mdl_t n;
    bit   is_data;
    n = m;
    n.flag = 0; n.disc = 0; n.abrt = 0; n.dv = 0; n.ferr = 0;
    if (rst) begin
      n.ones = 0; n.active = 0; n.cnt = 0; n.word = 0; n.sidx = 0; n.data = 0;
      return n;
    end
    if (!v) return n;
    is_data = 0;
    if (b) begin
      n.ones = (m.ones >= r + 2) ? r + 3 : m.ones + 1;
      if (n.ones >= r + 2) begin
        n.sidx = r + 2;
        if (m.ones == r + 1) begin
          n.abrt = 1; n.active = 0; n.cnt = 0; n.word = 0;
        end
      end else begin
        n.sidx  = n.ones;
        is_data = 1;
      end
    end else begin
      n.ones = 0;
      if (m.ones == r) begin
        n.sidx = r + 3; n.disc = 1;
      end else if (m.ones == r + 1) begin
        n.sidx = r + 4; n.flag = 1;
        n.ferr = m.active && (m.cnt != r + 2);
        n.cnt = 0; n.word = 0; n.active = 1;
      end else begin
        n.sidx  = 0;
        is_data = 1;
      end
    end
    if (is_data && m.active) begin
      n.word = m.word | (int'(b) << m.cnt);
      n.cnt  = m.cnt + 1;
      if (n.cnt == w) begin
        n.data = n.word; n.dv = 1; n.cnt = 0; n.word = 0;
      end
    end
    return n;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk) begin
    ma = step(ma, reset, va, ia, 5, 8);
    mb = step(mb, reset, vb, ib, 3, 6);
  end

  int total, bad;
  bit chk_en;
  int n_flag_a, n_disc_a, n_abort_a, n_dv_a, n_ferr_a, last_a;
  int n_flag_b, n_disc_b, n_dv_b, last_b;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // Per-cycle compare of both instances against the model, plus pulse tallies.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("a_state", int'(state_a), 1 << ma.sidx);
        chk("a_flag", int'(flag_a), int'(ma.flag));
        chk("a_discard", int'(disc_a), int'(ma.disc));
        chk("a_abort", int'(abort_a), int'(ma.abrt));
        chk("a_active", int'(fa_a), int'(ma.active));
        chk("a_data", int'(data_a), ma.data);
        chk("a_dvalid", int'(dv_a), int'(ma.dv));
        chk("a_ferr", int'(ferr_a), int'(ma.ferr));
        chk("b_state", int'(state_b), 1 << mb.sidx);
        chk("b_flag", int'(flag_b), int'(mb.flag));
        chk("b_discard", int'(disc_b), int'(mb.disc));
        chk("b_abort", int'(abort_b), int'(mb.abrt));
        chk("b_active", int'(fa_b), int'(mb.active));
        chk("b_data", int'(data_b), mb.data);
        chk("b_dvalid", int'(dv_b), int'(mb.dv));
        chk("b_ferr", int'(ferr_b), int'(mb.ferr));
        if (flag_a)  n_flag_a++;
        if (disc_a)  n_disc_a++;
        if (abort_a) n_abort_a++;
        if (ferr_a)  n_ferr_a++;
        if (dv_a) begin n_dv_a++; last_a = int'(data_a); end
        if (flag_b)  n_flag_b++;
        if (disc_b)  n_disc_b++;
        if (dv_b) begin n_dv_b++; last_b = int'(data_b); end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (2) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic send_a(input bit b, input int gap);
    va = 1'b1; ia = b;
    cyc();
    va = 1'b0; ia = 1'($urandom);
    repeat (gap) cyc();
  endtask

  task automatic send_b(input bit b, input int gap);
    vb = 1'b1; ib = b;
    cyc();
    vb = 1'b0; ib = 1'($urandom);
    repeat (gap) cyc();
  endtask

  task automatic send_byte_a(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) send_a(v[i], gap);
  endtask

  task automatic send_flag_b(input int gap);
    logic [5:0] f;
    f = 6'b011110;
    for (int i = 0; i < 6; i++) send_b(f[i], gap);
  endtask

  task automatic frame_a5(input int gap);
    int fl, dv, fe;
    fl = n_flag_a; dv = n_dv_a; fe = n_ferr_a;
    send_byte_a(8'h7E, gap);
    send_byte_a(8'hA5, gap);
    send_byte_a(8'h7E, gap);
    settle();
    chk("s1_flags", n_flag_a - fl, 2);
    chk("s1_words", n_dv_a - dv, 1);
    chk("s1_data", last_a, 32'hA5);
    chk("s1_ferr", n_ferr_a - fe, 0);
  endtask

  initial begin
    int base0, base1, base2;
    logic [8:0] stuffed;
    logic [6:0] pb;
    total = 0; bad = 0; chk_en = 0;
    va = 0; ia = 0; vb = 0; ib = 0;
    reset = 1'b1;
    fork
      compare_loop();
    join_none
    cyc();
    chk_en = 1;
    chk("rst_state", int'(state_a), 1);
    chk("rst_active", int'(fa_a), 0);
    chk("rst_data", int'(data_a), 0);
    cyc();
    reset = 1'b0;

    // Flag, 0xA5, flag.
    frame_a5(0);

    // Stuffed all-ones byte.
    base0 = n_disc_a; base1 = n_dv_a;
    stuffed = 9'b111_0_11111;
    for (int i = 0; i < 9; i++) send_a(stuffed[i], 0);
    settle();
    chk("stuff_disc", n_disc_a - base0, 1);
    chk("stuff_words", n_dv_a - base1, 1);
    chk("stuff_data", last_a, 32'hFF);

    // Abort after seven 1s, then recovery by a flag.
    send_byte_a(8'h7E, 0);
    base0 = n_abort_a; base1 = n_dv_a;
    for (int i = 0; i < 7; i++) send_a(1'b1, 0);
    settle();
    chk("abort_cnt", n_abort_a - base0, 1);
    chk("abort_words", n_dv_a - base1, 0);
    chk("abort_active", int'(fa_a), 0);
    base0 = n_flag_a;
    send_a(1'b0, 0);
    send_byte_a(8'h7E, 0);
    settle();
    chk("recover_flag", n_flag_a - base0, 1);
    chk("recover_active", int'(fa_a), 1);

    // Misaligned frame: 4 bits then a flag; residue completes one word.
    base0 = n_ferr_a; base1 = n_flag_a; base2 = n_dv_a;
    send_a(1'b1, 0); send_a(1'b0, 0); send_a(1'b1, 0); send_a(1'b0, 0);
    send_byte_a(8'h7E, 0);
    settle();
    chk("mis_ferr", n_ferr_a - base0, 1);
    chk("mis_flag", n_flag_a - base1, 1);
    chk("mis_words", n_dv_a - base2, 1);
    chk("mis_data", last_a, 32'hE5);

    // Same frame with in_valid gaps, then a reset mid-byte.
    do_reset();
    frame_a5(3);
    for (int i = 0; i < 4; i++) send_a(i[0], 0);
    reset = 1'b1; va = 1'b1; ia = 1'b1;
    cyc();
    reset = 1'b0; va = 1'b0;
    settle();
    chk("midrst_state", int'(state_a), 1);
    chk("midrst_active", int'(fa_a), 0);
    chk("midrst_data", int'(data_a), 0);
    chk("midrst_dv", int'(dv_a), 0);

    // RUN_LEN=3, DATA_W=6 instance.
    base0 = n_disc_b; base1 = n_dv_b; base2 = n_flag_b;
    send_flag_b(0);
    pb = 7'b111_0_111;
    for (int i = 0; i < 7; i++) send_b(pb[i], 0);
    settle();
    chk("b_flag_cnt", n_flag_b - base2, 1);
    chk("b_disc_cnt", n_disc_b - base0, 1);
    chk("b_words", n_dv_b - base1, 1);
    chk("b_data_lit", last_b, 32'h3F);

    // Random traffic on both instances.
    do_reset();
    repeat (1200) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      if ($urandom_range(0, 11) == 0) send_byte_a(8'h7E, int'($urandom_range(0, 1)));
      else send_a(1'($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    repeat (1200) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) send_flag_b(int'($urandom_range(0, 1)));
      else send_b(1'($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
